// File: rtl/roce_dma_rd_splitter_pkg.sv
// Shared types and chunk arithmetic for the RoCE DMA read splitter.
package roce_dma_rd_splitter_pkg;

    localparam int unsigned PAGE_BYTES = 4096;

    typedef struct packed {
        logic [31:0] len;
        logic [63:0] addr;
    } mem_cmd_t;

    typedef enum logic {StIdle, StSplit} split_state_e;

    // min(rem, max_burst, bytes left in the current 4 KiB page), 33-bit wide.
    function automatic logic [32:0] chunk_len(input logic [31:0] rem,
                                              input logic [11:0] page_off,
                                              input logic [32:0] max_burst);
        logic [32:0] page_left;
        logic [32:0] c;
        page_left = 33'(PAGE_BYTES) - {21'd0, page_off};
        c = {1'b0, rem};
        if (max_burst < c) c = max_burst;
        if (page_left < c) c = page_left;
        return c;
    endfunction

endpackage

// File: rtl/roce_dma_rd_splitter_fifo.sv
// 1-bit first-word-fall-through FIFO holding the "last sub-command" flag per issued read.
module roce_rd_last_fifo #(
    parameter int unsigned DEPTH = 16,
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic             data_i,
    input  logic             pop_i,
    output logic             data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    logic [DEPTH-1:0] mem_q;
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             push_ok, pop_ok;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];
    assign pop_ok  = pop_i && !empty_o;
    // A full FIFO still accepts a push when an entry leaves in the same cycle.
    assign push_ok = push_i && (!full_o || pop_ok);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q <= (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_q <= (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/roce_dma_rd_splitter.sv
// Splits RoCE read commands at 4 KiB / MAX_BURST boundaries and re-merges the DMA data tlast.
module roce_dma_rd_splitter
    import roce_dma_rd_splitter_pkg::*;
#(
    parameter int unsigned DATA_W      = 512,
    parameter int unsigned DEST_W      = 4,
    parameter int unsigned MAX_BURST   = 4096,
    parameter int unsigned OUTSTANDING = 16,
    localparam int unsigned KEEP_W     = DATA_W / 8,
    localparam int unsigned CNT_W      = $clog2(OUTSTANDING) + 1
) (
    input  logic              net_clk,
    input  logic              net_rst,
    input  logic              s_cmd_valid,
    output logic              s_cmd_ready,
    input  logic [95:0]       s_cmd_data,
    input  logic [DEST_W-1:0] s_cmd_dest,
    output logic              m_cmd_valid,
    input  logic              m_cmd_ready,
    output logic [95:0]       m_cmd_data,
    output logic [DEST_W-1:0] m_cmd_dest,
    input  logic              s_rd_valid,
    output logic              s_rd_ready,
    input  logic [DATA_W-1:0] s_rd_data,
    input  logic [KEEP_W-1:0] s_rd_keep,
    input  logic              s_rd_last,
    output logic              m_rd_valid,
    input  logic              m_rd_ready,
    output logic [DATA_W-1:0] m_rd_data,
    output logic [KEEP_W-1:0] m_rd_keep,
    output logic              m_rd_last,
    output logic [CNT_W-1:0]  outstanding,
    output logic              err_orphan_data
);

    split_state_e      state_q;
    mem_cmd_t          cmd_q;
    logic [DEST_W-1:0] dest_q;
    logic              s_cmd_ready_q;
    logic              err_q;

    logic [32:0] chunk;
    logic        last_sub, cmd_push;
    logic        fifo_full, fifo_empty, flag_head, fifo_pop;
    logic        rd_last_hs, orphan;

    assign chunk       = chunk_len(cmd_q.len, cmd_q.addr[11:0], 33'(MAX_BURST));
    assign last_sub    = ({1'b0, cmd_q.len} == chunk);
    assign m_cmd_valid = (state_q == StSplit) && !fifo_full;
    assign m_cmd_data  = {chunk[31:0], cmd_q.addr};
    assign m_cmd_dest  = dest_q;
    assign cmd_push    = m_cmd_valid && m_cmd_ready;
    assign s_cmd_ready = s_cmd_ready_q;

    always_ff @(posedge net_clk) begin
        if (net_rst) begin
            state_q       <= StIdle;
            cmd_q         <= '0;
            dest_q        <= '0;
            s_cmd_ready_q <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            if (orphan) err_q <= 1'b1;
            case (state_q)
                StIdle: begin
                    s_cmd_ready_q <= 1'b1;
                    if (s_cmd_valid && s_cmd_ready_q) begin
                        cmd_q  <= s_cmd_data;
                        dest_q <= s_cmd_dest;
                        // Zero-length commands are swallowed without any sub-command.
                        if (s_cmd_data[95:64] != 32'd0) begin
                            state_q       <= StSplit;
                            s_cmd_ready_q <= 1'b0;
                        end
                    end
                end
                StSplit: begin
                    if (cmd_push) begin
                        cmd_q.addr <= cmd_q.addr + 64'(chunk);
                        cmd_q.len  <= cmd_q.len - chunk[31:0];
                        if (last_sub) begin
                            state_q       <= StIdle;
                            s_cmd_ready_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign m_rd_valid = s_rd_valid;
    assign s_rd_ready = m_rd_ready;
    assign m_rd_data  = s_rd_data;
    assign m_rd_keep  = s_rd_keep;
    assign rd_last_hs = s_rd_valid && m_rd_ready && s_rd_last;
    // With nothing outstanding the DMA tlast is passed through unqualified.
    assign m_rd_last  = s_rd_last && (fifo_empty || flag_head);
    assign fifo_pop   = rd_last_hs && !fifo_empty;
    assign orphan     = rd_last_hs && fifo_empty;
    assign err_orphan_data = err_q;

    roce_rd_last_fifo #(
        .DEPTH(OUTSTANDING)
    ) u_last_fifo (
        .clk_i  (net_clk),
        .rst_i  (net_rst),
        .push_i (cmd_push),
        .data_i (last_sub),
        .pop_i  (fifo_pop),
        .data_o (flag_head),
        .full_o (fifo_full),
        .empty_o(fifo_empty),
        .count_o(outstanding)
    );

endmodule

// File: tb/tb_roce_dma_rd_splitter.sv
// Directed bench: default instance (a) plus a 2-deep, 256 B burst instance (b).
module tb_roce_dma_rd_splitter;

    logic         clk = 1'b0;
    logic         net_rst;
    int           checks = 0;
    int           errors = 0;

    logic         s_cmd_valid, s_cmd_ready, m_cmd_valid, m_cmd_ready;
    logic [95:0]  s_cmd_data, m_cmd_data;
    logic [3:0]   s_cmd_dest, m_cmd_dest;
    logic         s_rd_valid, s_rd_ready, s_rd_last, m_rd_valid, m_rd_ready, m_rd_last;
    logic [511:0] s_rd_data, m_rd_data;
    logic [63:0]  s_rd_keep, m_rd_keep;
    logic [4:0]   outstanding;
    logic         err_orphan;

    logic         b_s_cmd_valid, b_s_cmd_ready, b_m_cmd_valid, b_m_cmd_ready;
    logic [95:0]  b_s_cmd_data, b_m_cmd_data;
    logic [3:0]   b_s_cmd_dest, b_m_cmd_dest;
    logic         b_s_rd_valid, b_s_rd_ready, b_s_rd_last, b_m_rd_valid, b_m_rd_ready;
    logic         b_m_rd_last;
    logic [31:0]  b_s_rd_data, b_m_rd_data;
    logic [3:0]   b_s_rd_keep, b_m_rd_keep;
    logic [1:0]   b_outstanding;
    logic         b_err_orphan;

    always #5 clk = ~clk;

    roce_dma_rd_splitter dut_a (
        .net_clk(clk), .net_rst(net_rst),
        .s_cmd_valid(s_cmd_valid), .s_cmd_ready(s_cmd_ready),
        .s_cmd_data(s_cmd_data), .s_cmd_dest(s_cmd_dest),
        .m_cmd_valid(m_cmd_valid), .m_cmd_ready(m_cmd_ready),
        .m_cmd_data(m_cmd_data), .m_cmd_dest(m_cmd_dest),
        .s_rd_valid(s_rd_valid), .s_rd_ready(s_rd_ready), .s_rd_data(s_rd_data),
        .s_rd_keep(s_rd_keep), .s_rd_last(s_rd_last),
        .m_rd_valid(m_rd_valid), .m_rd_ready(m_rd_ready), .m_rd_data(m_rd_data),
        .m_rd_keep(m_rd_keep), .m_rd_last(m_rd_last),
        .outstanding(outstanding), .err_orphan_data(err_orphan)
    );

    roce_dma_rd_splitter #(
        .DATA_W(32), .DEST_W(4), .MAX_BURST(256), .OUTSTANDING(2)
    ) dut_b (
        .net_clk(clk), .net_rst(net_rst),
        .s_cmd_valid(b_s_cmd_valid), .s_cmd_ready(b_s_cmd_ready),
        .s_cmd_data(b_s_cmd_data), .s_cmd_dest(b_s_cmd_dest),
        .m_cmd_valid(b_m_cmd_valid), .m_cmd_ready(b_m_cmd_ready),
        .m_cmd_data(b_m_cmd_data), .m_cmd_dest(b_m_cmd_dest),
        .s_rd_valid(b_s_rd_valid), .s_rd_ready(b_s_rd_ready), .s_rd_data(b_s_rd_data),
        .s_rd_keep(b_s_rd_keep), .s_rd_last(b_s_rd_last),
        .m_rd_valid(b_m_rd_valid), .m_rd_ready(b_m_rd_ready), .m_rd_data(b_m_rd_data),
        .m_rd_keep(b_m_rd_keep), .m_rd_last(b_m_rd_last),
        .outstanding(b_outstanding), .err_orphan_data(b_err_orphan)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send_a(input logic [63:0] addr, input logic [31:0] len, input logic [3:0] dst);
        s_cmd_valid = 1'b1;
        s_cmd_data  = {len, addr};
        s_cmd_dest  = dst;
        tick;
        s_cmd_valid = 1'b0;
        #1;
    endtask

    task automatic send_b(input logic [63:0] addr, input logic [31:0] len);
        b_s_cmd_valid = 1'b1;
        b_s_cmd_data  = {len, addr};
        tick;
        b_s_cmd_valid = 1'b0;
        #1;
    endtask

    task automatic beat_a(input string tag, input logic last, input logic exp_last);
        s_rd_valid = 1'b1;
        s_rd_last  = last;
        m_rd_ready = 1'b1;
        #1;
        chk(tag, m_rd_last, exp_last);
        tick;
        s_rd_valid = 1'b0;
        s_rd_last  = 1'b0;
        #1;
    endtask

    task automatic beat_b(input string tag, input logic last, input logic exp_last);
        b_s_rd_valid = 1'b1;
        b_s_rd_last  = last;
        b_m_rd_ready = 1'b1;
        #1;
        chk(tag, b_m_rd_last, exp_last);
        tick;
        b_s_rd_valid = 1'b0;
        b_s_rd_last  = 1'b0;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        net_rst = 1'b1;
        s_cmd_valid = 0; s_cmd_data = '0; s_cmd_dest = '0; m_cmd_ready = 0;
        s_rd_valid = 0; s_rd_data = '0; s_rd_keep = '0; s_rd_last = 0; m_rd_ready = 0;
        b_s_cmd_valid = 0; b_s_cmd_data = '0; b_s_cmd_dest = '0; b_m_cmd_ready = 0;
        b_s_rd_valid = 0; b_s_rd_data = '0; b_s_rd_keep = '0; b_s_rd_last = 0;
        b_m_rd_ready = 0;
        tick; tick;
        chk("rst_s_cmd_ready", s_cmd_ready, 0);
        chk("rst_m_cmd_valid", m_cmd_valid, 0);
        chk("rst_outstanding", outstanding, 0);
        chk("rst_err", err_orphan, 0);
        chk("b_rst_s_cmd_ready", b_s_cmd_ready, 0);
        net_rst = 1'b0;
        tick;
        chk("idle_ready", s_cmd_ready, 1);

        // Single sub-command, one data beat.
        send_a(64'h1000, 32'd64, 4'h5);
        chk("t1_valid", m_cmd_valid, 1);
        chk("t1_data", m_cmd_data, {32'd64, 64'h1000});
        chk("t1_dest", m_cmd_dest, 4'h5);
        chk("t1_busy", s_cmd_ready, 0);
        m_cmd_ready = 1'b1;
        tick;
        m_cmd_ready = 1'b0;
        #1;
        chk("t1_out1", outstanding, 1);
        chk("t1_valid_off", m_cmd_valid, 0);
        s_rd_data = {16{32'hA5A5_0001}};
        s_rd_keep = 64'hFFFF_FFFF_FFFF_FFFF;
        s_rd_valid = 1'b1; s_rd_last = 1'b1; m_rd_ready = 1'b1;
        #1;
        chk("t1_rd_data", m_rd_data, {16{32'hA5A5_0001}});
        chk("t1_rd_keep", m_rd_keep, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("t1_rd_valid", m_rd_valid, 1);
        chk("t1_rd_last", m_rd_last, 1);
        tick;
        s_rd_valid = 1'b0; s_rd_last = 1'b0;
        #1;
        chk("t1_out0", outstanding, 0);

        // Page crossing: 64 B then 192 B; tlast only on final merged beat.
        send_a(64'h0FC0, 32'd256, 4'h3);
        chk("t2_sub0", m_cmd_data, {32'd64, 64'h0FC0});
        tick;
        chk("t2_hold", m_cmd_data, {32'd64, 64'h0FC0});
        m_cmd_ready = 1'b1;
        tick;
        chk("t2_sub1", m_cmd_data, {32'd192, 64'h1000});
        chk("t2_sub1_valid", m_cmd_valid, 1);
        tick;
        m_cmd_ready = 1'b0;
        #1;
        chk("t2_done", m_cmd_valid, 0);
        chk("t2_out2", outstanding, 2);
        beat_a("t2_beat1", 1'b1, 1'b0);
        beat_a("t2_beat2", 1'b0, 1'b0);
        beat_a("t2_beat3", 1'b0, 1'b0);
        beat_a("t2_beat4", 1'b1, 1'b1);
        chk("t2_out0", outstanding, 0);

        // 10000 B from 0: three back-to-back sub-commands.
        m_cmd_ready = 1'b1;
        send_a(64'h0, 32'd10000, 4'h1);
        chk("t3_sub0", m_cmd_data, {32'd4096, 64'h0});
        tick;
        chk("t3_sub1", m_cmd_data, {32'd4096, 64'h1000});
        tick;
        chk("t3_sub2", m_cmd_data, {32'd1808, 64'h2000});
        chk("t3_sub2_valid", m_cmd_valid, 1);
        tick;
        m_cmd_ready = 1'b0;
        #1;
        chk("t3_done", m_cmd_valid, 0);
        chk("t3_out3", outstanding, 3);
        beat_a("t3_beat0", 1'b1, 1'b0);
        beat_a("t3_beat1", 1'b1, 1'b0);
        beat_a("t3_beat2", 1'b1, 1'b1);
        chk("t3_out0", outstanding, 0);

        // Zero-length command is dropped; next command accepted immediately.
        s_cmd_valid = 1'b1;
        s_cmd_data  = {32'd0, 64'h40};
        tick;
        s_cmd_data  = {32'd64, 64'h2000};
        #1;
        chk("t4_no_valid", m_cmd_valid, 0);
        chk("t4_ready", s_cmd_ready, 1);
        tick;
        s_cmd_valid = 1'b0;
        #1;
        chk("t4_next_valid", m_cmd_valid, 1);
        chk("t4_next_data", m_cmd_data, {32'd64, 64'h2000});
        m_cmd_ready = 1'b1;
        tick;
        m_cmd_ready = 1'b0;
        beat_a("t4_beat", 1'b1, 1'b1);
        chk("t4_out0", outstanding, 0);

        // Orphan tlast.
        chk("t5_err_pre", err_orphan, 0);
        beat_a("t5_orphan_last", 1'b1, 1'b1);
        chk("t5_err", err_orphan, 1);
        tick; tick;
        chk("t5_err_sticky", err_orphan, 1);
        chk("t5_out0", outstanding, 0);

        // Reset mid-split with one sub-command outstanding.
        send_a(64'h0, 32'd10000, 4'h2);
        m_cmd_ready = 1'b1;
        tick;
        m_cmd_ready = 1'b0;
        #1;
        chk("t6_out1", outstanding, 1);
        chk("t6_split_valid", m_cmd_valid, 1);
        net_rst = 1'b1;
        tick;
        chk("t6_rst_ready", s_cmd_ready, 0);
        chk("t6_rst_valid", m_cmd_valid, 0);
        chk("t6_rst_out", outstanding, 0);
        chk("t6_rst_err", err_orphan, 0);
        net_rst = 1'b0;
        tick;
        chk("t6_idle_ready", s_cmd_ready, 1);
        beat_a("t6_late_beat", 1'b1, 1'b1);
        chk("t6_late_err", err_orphan, 1);

        // Instance b: two-entry FIFO stalls the third sub-command.
        b_m_cmd_ready = 1'b1;
        send_b(64'h0, 32'd64);
        tick;
        send_b(64'h40, 32'd64);
        tick;
        chk("b_out2", b_outstanding, 2);
        send_b(64'h80, 32'd64);
        chk("b_stall", b_m_cmd_valid, 0);
        tick;
        chk("b_stall2", b_m_cmd_valid, 0);
        chk("b_busy", b_s_cmd_ready, 0);
        b_s_rd_data = 32'hC0DE_0042;
        b_s_rd_keep = 4'hF;
        b_s_rd_valid = 1'b1; b_s_rd_last = 1'b1; b_m_rd_ready = 1'b1;
        #1;
        chk("b_rd_data", b_m_rd_data, 32'hC0DE_0042);
        chk("b_pop_last", b_m_rd_last, 1);
        chk("b_pop_cycle_stall", b_m_cmd_valid, 0);
        tick;
        b_s_rd_valid = 1'b0; b_s_rd_last = 1'b0;
        #1;
        chk("b_resume", b_m_cmd_valid, 1);
        chk("b_resume_data", b_m_cmd_data, {32'd64, 64'h80});
        chk("b_out1", b_outstanding, 1);
        tick;
        chk("b_out2_again", b_outstanding, 2);
        chk("b_idle", b_m_cmd_valid, 0);
        beat_b("b_drain0", 1'b1, 1'b1);
        beat_b("b_drain1", 1'b1, 1'b1);
        chk("b_out0", b_outstanding, 0);

        // Instance b: MAX_BURST limit, then page limit below MAX_BURST.
        b_m_cmd_ready = 1'b0;
        send_b(64'h0, 32'd300);
        chk("b_burst0", b_m_cmd_data, {32'd256, 64'h0});
        b_m_cmd_ready = 1'b1;
        tick;
        chk("b_burst1", b_m_cmd_data, {32'd44, 64'h100});
        tick;
        chk("b_burst_out2", b_outstanding, 2);
        beat_b("b_burst_beat0", 1'b1, 1'b0);
        beat_b("b_burst_beat1", 1'b1, 1'b1);
        b_m_cmd_ready = 1'b0;
        send_b(64'h0F80, 32'd300);
        chk("b_page0", b_m_cmd_data, {32'd128, 64'h0F80});
        b_m_cmd_ready = 1'b1;
        tick;
        chk("b_page1", b_m_cmd_data, {32'd172, 64'h1000});
        tick;
        b_m_cmd_ready = 1'b0;
        #1;
        chk("b_page_out2", b_outstanding, 2);
        chk("b_err_clean", b_err_orphan, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
